// File: rtl/wb_regfile_sb.sv
// Writeback stage: selects the WB result, writes the 32x32 register file, serves two decode read ports and a load scoreboard.
// Latency: result_WB, rd1_ID/rd2_ID and stall_ID are combinational; register and pending-bit updates land on the next clk edge.
// Backpressure: stall_ID holds decode while a source register awaits load data; ld_issue_ID is ignored while stalled.
// Optional feature: define WB_BYPASS_EN for write-through reads and same-cycle stall release.
module wb_regfile_sb #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] aluresult_WB,
    input  logic [DW-1:0] readdata_WB,
    input  logic [AW-1:0] writereg_WB,
    input  logic          regwrite_WB,
    input  logic          memtoreg_WB,
    input  logic [AW-1:0] rs_ID,
    input  logic [AW-1:0] rt_ID,
    output logic [DW-1:0] rd1_ID,
    output logic [DW-1:0] rd2_ID,
    input  logic          ld_issue_ID,
    input  logic [AW-1:0] ld_dest_ID,
    output logic [DW-1:0] result_WB,
    output logic          stall_ID
);

    logic [DW-1:0]    r_regs [NREGS];
    logic [NREGS-1:0] r_pend;

    logic          w_wr_en;
    logic          w_ld_set;
    logic          w_ld_clr;
    logic          w_rs_hazard;
    logic          w_rt_hazard;
    logic [DW-1:0] w_rd1;
    logic [DW-1:0] w_rd2;

    assign w_wr_en  = regwrite_WB && (writereg_WB != '0);
    // A stalled decode cannot hand a load onward, so no reservation is made then.
    assign w_ld_set = ld_issue_ID && !stall_ID && (ld_dest_ID != '0);
    assign w_ld_clr = regwrite_WB && memtoreg_WB;

    // Writeback mux feeding both the register file and the forwarding network.
    always_comb begin
        result_WB = memtoreg_WB ? readdata_WB : aluresult_WB;
    end

    // Register file write; entry 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[writereg_WB] <= result_WB;
        end
    end

    // Load scoreboard: clear applied first so a same-register set from a newer load wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            if (w_ld_clr) begin
                r_pend[writereg_WB] <= 1'b0;
            end
            if (w_ld_set) begin
                r_pend[ld_dest_ID] <= 1'b1;
            end
        end
    end

    // Read ports and hazard detection; register 0 never reads nonzero nor stalls.
    always_comb begin
        w_rd1       = (rs_ID == '0) ? '0 : r_regs[rs_ID];
        w_rd2       = (rt_ID == '0) ? '0 : r_regs[rt_ID];
        w_rs_hazard = r_pend[rs_ID] && (rs_ID != '0);
        w_rt_hazard = r_pend[rt_ID] && (rt_ID != '0);
`ifdef WB_BYPASS_EN
        if (w_wr_en && (writereg_WB == rs_ID)) begin
            w_rd1 = result_WB;
        end
        if (w_wr_en && (writereg_WB == rt_ID)) begin
            w_rd2 = result_WB;
        end
        if (w_ld_clr && (writereg_WB == rs_ID)) begin
            w_rs_hazard = 1'b0;
        end
        if (w_ld_clr && (writereg_WB == rt_ID)) begin
            w_rt_hazard = 1'b0;
        end
`endif
    end

    // Outputs forced quiet while reset is held, independent of the bypass path.
    always_comb begin
        rd1_ID   = reset ? '0 : w_rd1;
        rd2_ID   = reset ? '0 : w_rd2;
        stall_ID = !reset && (w_rs_hazard || w_rt_hazard);
    end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed bench for wb_regfile_sb: register writes, reg0 behaviour, load scoreboard, and reset.
// Expected values are hand-computed; bypass-dependent values follow the WB_BYPASS_EN define.
// Inputs are driven 1ns after the rising edge and outputs are sampled 1ns later.
module tb_wb_regfile_sb;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aluresult_WB;
    logic [31:0] readdata_WB;
    logic [4:0]  writereg_WB;
    logic        regwrite_WB;
    logic        memtoreg_WB;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;
    logic [31:0] rd1_ID;
    logic [31:0] rd2_ID;
    logic        ld_issue_ID;
    logic [4:0]  ld_dest_ID;
    logic [31:0] result_WB;
    logic        stall_ID;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile_sb dut (
        .clk          (clk),
        .reset        (reset),
        .aluresult_WB (aluresult_WB),
        .readdata_WB  (readdata_WB),
        .writereg_WB  (writereg_WB),
        .regwrite_WB  (regwrite_WB),
        .memtoreg_WB  (memtoreg_WB),
        .rs_ID        (rs_ID),
        .rt_ID        (rt_ID),
        .rd1_ID       (rd1_ID),
        .rd2_ID       (rd2_ID),
        .ld_issue_ID  (ld_issue_ID),
        .ld_dest_ID   (ld_dest_ID),
        .result_WB    (result_WB),
        .stall_ID     (stall_ID)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regwrite_WB = 1'b0;
        memtoreg_WB = 1'b0;
        writereg_WB = '0;
        ld_issue_ID = 1'b0;
        ld_dest_ID  = '0;
    endtask

    initial begin
        reset        = 1'b1;
        aluresult_WB = '0;
        readdata_WB  = '0;
        rs_ID        = '0;
        rt_ID        = '0;
        idle();

        // Reset state
        #3;
        rs_ID = 5'd5;
        rt_ID = 5'd9;
        #1;
        chk("rst_rd1", rd1_ID, 32'h0);
        chk("rst_rd2", rd2_ID, 32'h0);
        chk("rst_stall", {31'b0, stall_ID}, 32'h0);
        step();
        step();
        reset = 1'b0;
        step();

        // T2: ALU write to r3
        regwrite_WB  = 1'b1;
        memtoreg_WB  = 1'b0;
        writereg_WB  = 5'd3;
        aluresult_WB = 32'h0000_1234;
        readdata_WB  = 32'h0BAD_0BAD;
        rs_ID        = 5'd3;
        #1;
        chk("t2_result", result_WB, 32'h0000_1234);
        chk("t2_same_cycle_rd1", rd1_ID, BYP ? 32'h0000_1234 : 32'h0);
        step();
        idle();
        #1;
        chk("t2_next_rd1", rd1_ID, 32'h0000_1234);

        // T3: load write to r7
        regwrite_WB  = 1'b1;
        memtoreg_WB  = 1'b1;
        writereg_WB  = 5'd7;
        readdata_WB  = 32'hDEAD_BEEF;
        aluresult_WB = 32'h0000_0055;
        #1;
        chk("t3_result", result_WB, 32'hDEAD_BEEF);
        step();
        idle();
        rt_ID = 5'd7;
        #1;
        chk("t3_rd2", rd2_ID, 32'hDEAD_BEEF);
        chk("t3_rd1_r3_kept", rd1_ID, 32'h0000_1234);

        // T4: write and load to r0 are both dropped
        regwrite_WB  = 1'b1;
        memtoreg_WB  = 1'b0;
        writereg_WB  = 5'd0;
        aluresult_WB = 32'hFFFF_FFFF;
        ld_issue_ID  = 1'b1;
        ld_dest_ID   = 5'd0;
        rs_ID        = 5'd0;
        rt_ID        = 5'd0;
        #1;
        chk("t4_rd1_same", rd1_ID, 32'h0);
        step();
        idle();
        #1;
        chk("t4_rd1", rd1_ID, 32'h0);
        chk("t4_stall", {31'b0, stall_ID}, 32'h0);

        // T5: load-use on r9
        ld_issue_ID = 1'b1;
        ld_dest_ID  = 5'd9;
        step();
        idle();
        rs_ID = 5'd9;
        #1;
        chk("t5_stall_set", {31'b0, stall_ID}, 32'h1);
        ld_issue_ID = 1'b1;
        ld_dest_ID  = 5'd10;
        step();
        idle();
        #1;
        chk("t5_stall_hold", {31'b0, stall_ID}, 32'h1);
        regwrite_WB = 1'b1;
        memtoreg_WB = 1'b1;
        writereg_WB = 5'd9;
        readdata_WB = 32'h0000_A5A5;
        #1;
        chk("t5_stall_wb_cycle", {31'b0, stall_ID}, BYP ? 32'h0 : 32'h1);
        chk("t5_rd1_wb_cycle", rd1_ID, BYP ? 32'h0000_A5A5 : 32'h0);
        step();
        idle();
        #1;
        chk("t5_stall_after", {31'b0, stall_ID}, 32'h0);
        chk("t5_rd1_after", rd1_ID, 32'h0000_A5A5);
        rs_ID = 5'd10;
        #1;
        chk("t5_r10_not_pending", {31'b0, stall_ID}, 32'h0);

        // T6: same-register set/clear collision on r4
        rs_ID       = 5'd0;
        ld_issue_ID = 1'b1;
        ld_dest_ID  = 5'd4;
        step();
        regwrite_WB = 1'b1;
        memtoreg_WB = 1'b1;
        writereg_WB = 5'd4;
        readdata_WB = 32'h0000_4444;
        ld_issue_ID = 1'b1;
        ld_dest_ID  = 5'd4;
        step();
        idle();
        rs_ID = 5'd4;
        #1;
        chk("t6_set_wins", {31'b0, stall_ID}, 32'h1);
        chk("t6_r4_data", rd1_ID, 32'h0000_4444);

        // Set and clear of different registers in one cycle
        rs_ID       = 5'd0;
        ld_issue_ID = 1'b1;
        ld_dest_ID  = 5'd12;
        step();
        regwrite_WB = 1'b1;
        memtoreg_WB = 1'b1;
        writereg_WB = 5'd12;
        readdata_WB = 32'h0000_1212;
        ld_issue_ID = 1'b1;
        ld_dest_ID  = 5'd11;
        step();
        idle();
        rt_ID = 5'd12;
        #1;
        chk("diff_clr_r12", {31'b0, stall_ID}, 32'h0);
        rt_ID = 5'd11;
        #1;
        chk("diff_set_r11", {31'b0, stall_ID}, 32'h1);

        // T1: asynchronous reset mid-cycle with pending loads and written registers
        rs_ID = 5'd3;
        rt_ID = 5'd4;
        #2;
        reset = 1'b1;
        #1;
        chk("t1_rd1", rd1_ID, 32'h0);
        chk("t1_rd2", rd2_ID, 32'h0);
        chk("t1_stall", {31'b0, stall_ID}, 32'h0);
        step();
        reset = 1'b0;
        step();
        rs_ID = 5'd5;
        rt_ID = 5'd3;
        #1;
        chk("t1_r5_after", rd1_ID, 32'h0);
        chk("t1_r3_cleared", rd2_ID, 32'h0);
        rs_ID = 5'd4;
        rt_ID = 5'd11;
        #1;
        chk("t1_pend_cleared", {31'b0, stall_ID}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
